// File: rtl/n64_pif_serial_engine.sv
// N64 PIF serial engine: decodes a header from the RCP line, then streams PIF RAM words out or in.
// Optional macro PIF_SERIAL_TIMEOUT_EN adds a write-acknowledge timeout that pulses xfer_err.
module n64_pif_serial_engine #(
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned BURST_WORDS = 16,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              reset_l,
  input  logic              n64_rsp_in,
  output logic              n64_pif_out,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wren,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              xfer_done,
  output logic              xfer_err,
  output logic [1:0]        last_type
);

  localparam int unsigned HDR_W  = 2 + ADDR_W;
  localparam int unsigned HCNT_W = $clog2(HDR_W + 1);
  localparam int unsigned BIT_W  = $clog2(DATA_W);
  localparam int unsigned WCNT_W = $clog2(BURST_WORDS + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_HDR, ST_DECODE, ST_RD_ACK, ST_RD_DATA, ST_WR_ACK, ST_WR_WAIT, ST_WR_DATA
  } state_t;

  state_t              r_state;
  logic                r_s1, r_s2, r_s3;
  logic [HCNT_W-1:0]   r_hcnt;
  logic [HDR_W-1:0]    r_hdr;
  logic [DATA_W-1:0]   r_sh;
  logic [BIT_W-1:0]    r_bit;
  logic [WCNT_W-1:0]   r_words;
  logic                r_wr_fin;
  logic                r_out;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_wren;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_busy;
  logic                r_done;
  logic [1:0]          r_type;
  logic                w_fall;

`ifdef PIF_SERIAL_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] r_to_cnt;
  logic            r_err;
  assign xfer_err = r_err;
`else
  assign xfer_err = 1'b0;
`endif

  assign w_fall      = r_s3 & ~r_s2;
  assign n64_pif_out = r_out;
  assign mem_addr    = r_addr;
  assign mem_wren    = r_wren;
  assign mem_wdata   = r_wdata;
  assign busy        = r_busy;
  assign xfer_done   = r_done;
  assign last_type   = r_type;

  // Synchroniser, transfer sequencer and all registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      r_state  <= ST_IDLE;
      r_s1     <= 1'b1;
      r_s2     <= 1'b1;
      r_s3     <= 1'b1;
      r_hcnt   <= '0;
      r_hdr    <= '0;
      r_sh     <= '0;
      r_bit    <= '0;
      r_words  <= '0;
      r_wr_fin <= 1'b0;
      r_out    <= 1'b1;
      r_addr   <= '0;
      r_wren   <= 1'b0;
      r_wdata  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_type   <= 2'b00;
`ifdef PIF_SERIAL_TIMEOUT_EN
      r_to_cnt <= '0;
      r_err    <= 1'b0;
`endif
    end else begin
      r_s1   <= n64_rsp_in;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_wren <= 1'b0;
      r_done <= 1'b0;
`ifdef PIF_SERIAL_TIMEOUT_EN
      r_err  <= 1'b0;
`endif
      // Write address advances the cycle after each strobe.
      if (r_wren) r_addr <= r_addr + ADDR_W'(1);

      case (r_state)
        ST_IDLE: begin
          if (w_fall) begin
            r_state <= ST_HDR;
            r_hcnt  <= HCNT_W'(HDR_W);
            r_busy  <= 1'b1;
          end
        end
        ST_HDR: begin
          r_hdr  <= {r_hdr[HDR_W-2:0], r_s2};
          r_hcnt <= r_hcnt - HCNT_W'(1);
          if (r_hcnt == HCNT_W'(1)) r_state <= ST_DECODE;
        end
        ST_DECODE: begin
          r_addr  <= r_hdr[ADDR_W-1:0];
          r_type  <= r_hdr[HDR_W-1 -: 2];
          r_words <= r_hdr[HDR_W-2] ? WCNT_W'(BURST_WORDS) : WCNT_W'(1);
          r_out   <= 1'b0;
          r_state <= r_hdr[HDR_W-1] ? ST_WR_ACK : ST_RD_ACK;
        end
        ST_RD_ACK: begin
          r_out   <= mem_rdata[DATA_W-1];
          r_sh    <= {mem_rdata[DATA_W-2:0], 1'b0};
          r_bit   <= BIT_W'(DATA_W - 1);
          r_state <= ST_RD_DATA;
        end
        ST_RD_DATA: begin
          if (r_bit == BIT_W'(DATA_W - 1)) r_addr <= r_addr + ADDR_W'(1);
          if (r_bit != '0) begin
            r_out <= r_sh[DATA_W-1];
            r_sh  <= {r_sh[DATA_W-2:0], 1'b0};
            r_bit <= r_bit - BIT_W'(1);
          end else if (r_words > WCNT_W'(1)) begin
            r_words <= r_words - WCNT_W'(1);
            r_out   <= mem_rdata[DATA_W-1];
            r_sh    <= {mem_rdata[DATA_W-2:0], 1'b0};
            r_bit   <= BIT_W'(DATA_W - 1);
          end else begin
            r_out   <= 1'b1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_WR_ACK: begin
          r_out   <= 1'b1;
          r_state <= ST_WR_WAIT;
`ifdef PIF_SERIAL_TIMEOUT_EN
          r_to_cnt <= '0;
`endif
        end
        ST_WR_WAIT: begin
          if (w_fall) begin
            r_state  <= ST_WR_DATA;
            r_bit    <= BIT_W'(DATA_W - 1);
            r_wr_fin <= 1'b0;
          end
`ifdef PIF_SERIAL_TIMEOUT_EN
          else if (r_to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
`endif
        end
        ST_WR_DATA: begin
          if (r_wr_fin) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_sh  <= {r_sh[DATA_W-2:0], r_s2};
            r_bit <= r_bit - BIT_W'(1);
            if (r_bit == '0) begin
              r_wdata <= {r_sh[DATA_W-2:0], r_s2};
              r_wren  <= 1'b1;
              r_bit   <= BIT_W'(DATA_W - 1);
              r_words <= r_words - WCNT_W'(1);
              if (r_words == WCNT_W'(1)) r_wr_fin <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_out   <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/n64_pif_serial_engine.md
N64_PIF_SERIAL_ENGINE -- requirements
Module: n64_pif_serial_engine

Interface
REQ-001 Parameter ADDR_W, default 9: word-address width of the PIF RAM port.
REQ-002 Parameter DATA_W, default 32: bits per word; legal values 8, 16, 32.
REQ-003 Parameter BURST_WORDS, default 16: words per burst transfer; power of two, 2..64.
REQ-004 Parameter TIMEOUT_CYC, default 4096: write-acknowledge wait limit, in clk cycles.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 reset_l  in  1  reset, synchronous and active-low.
REQ-007 n64_rsp_in  in  1  serial line from the RCP; idles high; asynchronous.
REQ-008 n64_pif_out  out  1  serial line to the RCP; idles high.
REQ-009 mem_addr  out  ADDR_W  RAM word address.
REQ-010 mem_wren  out  1  RAM write strobe, one cycle per word.
REQ-011 mem_wdata  out  DATA_W  RAM write data.
REQ-012 mem_rdata  in  DATA_W  RAM read data; valid one cycle after mem_addr.
REQ-013 busy  out  1  high whenever the state is not IDLE.
REQ-014 xfer_done  out  1  one-cycle pulse when a transfer completes.
REQ-015 xfer_err  out  1  one-cycle pulse when a transfer aborts.
REQ-016 last_type  out  2  type code of the most recently decoded header.

Function
REQ-017 n64_rsp_in shall pass through a two-flop synchroniser (s1, s2); all sampling uses s2, and edge detection compares s2 with its one-cycle-delayed copy s3.
REQ-018 States: IDLE, HDR, DECODE, RD_ACK, RD_DATA, WR_ACK, WR_WAIT, WR_DATA.
REQ-019 In IDLE, s3=1 and s2=0 (falling edge) shall enter HDR with the bit counter set to 2+ADDR_W.
REQ-020 HDR shall shift s2 in MSB-first, one bit per cycle; after 2+ADDR_W bits it shall enter DECODE.
REQ-021 Header format: the top 2 bits are the type (00 read word, 01 read burst, 10 write word, 11 write burst); the remaining bits are the start address.
REQ-022 DECODE shall drive mem_addr with the start address, update last_type, and enter RD_ACK for reads or WR_ACK for writes.
REQ-023 RD_ACK: n64_pif_out=0 for exactly one cycle; load the shift register from mem_rdata; enter RD_DATA.
REQ-024 RD_DATA: output DATA_W×N bits MSB-first, one per cycle, where N=1 for word transfers and N=BURST_WORDS for bursts.
REQ-025 In RD_DATA, mem_addr shall increment on the first bit cycle of each word, and mem_rdata shall be loaded at each word boundary.
REQ-026 After the last read bit, RD_DATA shall pulse xfer_done and return to IDLE.
REQ-027 WR_ACK: n64_pif_out=0 for exactly one cycle, then enter WR_WAIT.
REQ-028 WR_WAIT: a falling edge on s2/s3 shall enter WR_DATA.
REQ-029 WR_DATA: shift in DATA_W×N bits MSB-first.
REQ-030 In WR_DATA, each completed word shall raise mem_wren for one cycle with mem_wdata equal to that word at the current mem_addr; mem_addr shall increment the cycle after each write.
REQ-031 After the final write, WR_DATA shall pulse xfer_done and return to IDLE.
REQ-032 mem_addr arithmetic shall be modulo 2^ADDR_W; a burst starting near the top of the address space shall wrap to 0 silently.
REQ-033 Line edges while busy=1 (other than the WR_WAIT acknowledge) shall be ignored; no re-arming mid-transfer.
REQ-034 xfer_done and xfer_err shall never be high in the same cycle.
REQ-035 n64_pif_out shall be 1 in every state except RD_ACK, WR_ACK and RD_DATA.

Reset
REQ-036 While reset_l=0 at a clk edge: state=IDLE; n64_pif_out=1; s1, s2 and s3 = 1; mem_wren=0; mem_addr=0; mem_wdata=0; busy=0; xfer_done=0; xfer_err=0; last_type=0.
REQ-037 Reset asserted mid-transfer shall abandon the transfer with no further mem_wren.
REQ-038 After reset, a new start edge shall be accepted no earlier than 3 cycles after reset_l rises.

Configuration
REQ-039 With PIF_SERIAL_TIMEOUT_EN defined, WR_WAIT shall count cycles; on reaching TIMEOUT_CYC it shall pulse xfer_err, perform no RAM writes and return to IDLE.
REQ-040 Without PIF_SERIAL_TIMEOUT_EN, WR_WAIT shall wait indefinitely, xfer_err shall be tied to 0, and no timeout counter shall be synthesised.

Verification
REQ-041 Header 00 + addr 0x005, RAM[5]=0xDEADBEEF -> one-cycle ack low, then 32 bits 0xDEADBEEF MSB-first, then xfer_done.
REQ-042 Header 01 + addr 0x1F8, BURST_WORDS=16 -> 512 bits are output; mem_addr runs 0x1F8..0x1FF then 0x000..0x007 (wrap).
REQ-043 Header 10 + addr 0x010, RSP ack edge, data 0x12345678 -> exactly one mem_wren, at addr 0x010 with mem_wdata 0x12345678.
REQ-044 Header 11 + addr 0x000, 16 words -> 16 mem_wren pulses at addrs 0..15 with matching data, then xfer_done.
REQ-045 With PIF_SERIAL_TIMEOUT_EN and TIMEOUT_CYC=64, write header with no RSP ack -> xfer_err pulse 64 cycles after entering WR_WAIT, zero writes, busy returns to 0.
REQ-046 reset_l pulsed low at bit 100 of a write burst -> IDLE, n64_pif_out=1, no mem_wren after reset, and the next transfer completes correctly.
